// File: rtl/wifi_uart_fc.sv
// wifi_uart_fc: UART transceiver with TX/RX FIFOs and RTS/CTS flow control.
// A frame is one start bit, DATA_BITS data bits sent LSB first, optional parity, then STOP_BITS stop bits.
module wifi_uart_fc #(
  parameter int unsigned CLK_DIV    = 434,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned RTS_MARGIN = 4
) (
  input  logic                        clk_clk,
  input  logic                        reset_reset_n,
  input  logic [DATA_BITS-1:0]        tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic [DATA_BITS-1:0]        rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic [$clog2(FIFO_DEPTH):0] tx_level,
  output logic [$clog2(FIFO_DEPTH):0] rx_level,
  output logic                        err_frame,
  output logic                        err_parity,
  output logic                        err_overrun,
  input  logic                        rxd,
  output logic                        txd,
  input  logic                        cts_n,
  output logic                        rts_n
);

  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W   = PTR_W + 1;
  localparam int unsigned CNT_W   = $clog2(CLK_DIV);
  localparam int unsigned BIT_W   = $clog2(DATA_BITS + 1);
  localparam int unsigned HALF    = CLK_DIV / 2;
  localparam int unsigned RTS_THR = FIFO_DEPTH - RTS_MARGIN;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_e;

  // Two-flop synchronisers; rx_prev_q provides the falling-edge reference
  logic rxd_s1_q, rxd_s2_q, rx_prev_q, cts_s1_q, cts_s2_q;
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      rxd_s1_q  <= 1'b1;
      rxd_s2_q  <= 1'b1;
      rx_prev_q <= 1'b1;
      cts_s1_q  <= 1'b1;
      cts_s2_q  <= 1'b1;
    end else begin
      rxd_s1_q  <= rxd;
      rxd_s2_q  <= rxd_s1_q;
      rx_prev_q <= rxd_s2_q;
      cts_s1_q  <= cts_n;
      cts_s2_q  <= cts_s1_q;
    end
  end

  logic                 rx_s;
  assign rx_s = rxd_s2_q;

  // ---------------- TX FIFO ----------------
  logic [DATA_BITS-1:0] tx_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     tx_wp_q, tx_rp_q;
  logic [LVL_W-1:0]     tx_cnt_q, tx_cnt_d;
  logic                 tx_ready_q, tx_push, tx_pop;
  logic [DATA_BITS-1:0] tx_head;
  logic                 tx_head_par;

  assign tx_push     = tx_valid && tx_ready_q;
  assign tx_head     = tx_mem_q[tx_rp_q];
  assign tx_head_par = (PARITY == 1) ? ~^tx_head : ^tx_head;

  always_comb begin
    tx_cnt_d = tx_cnt_q;
    if (tx_push && !tx_pop)      tx_cnt_d = tx_cnt_q + LVL_W'(1);
    else if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - LVL_W'(1);
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      tx_wp_q    <= '0;
      tx_rp_q    <= '0;
      tx_cnt_q   <= '0;
      tx_ready_q <= 1'b0;
    end else begin
      if (tx_push) tx_wp_q <= tx_wp_q + PTR_W'(1);
      if (tx_pop)  tx_rp_q <= tx_rp_q + PTR_W'(1);
      tx_cnt_q   <= tx_cnt_d;
      tx_ready_q <= (tx_cnt_d != LVL_W'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge clk_clk) begin
    if (tx_push) tx_mem_q[tx_wp_q] <= tx_data;
  end

  // ---------------- TX FSM ----------------
  state_e               tx_state_q;
  logic [CNT_W-1:0]     tx_div_q;
  logic [BIT_W-1:0]     tx_bit_q;
  logic [DATA_BITS-1:0] tx_shift_q;
  logic                 tx_par_q, txd_q;
  logic                 tx_bit_end, tx_frame_end;

  assign tx_bit_end   = (tx_div_q == CNT_W'(CLK_DIV - 1));
  assign tx_frame_end = (tx_state_q == S_STOP) && tx_bit_end &&
                        (tx_bit_q == BIT_W'(STOP_BITS - 1));
  // A new frame may follow the last stop bit directly, so no idle gap is inserted
  assign tx_pop = !cts_s2_q && (tx_cnt_q != '0) &&
                  ((tx_state_q == S_IDLE) || tx_frame_end);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      tx_state_q <= S_IDLE;
      tx_div_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      txd_q      <= 1'b1;
    end else begin
      if (tx_state_q != S_IDLE) tx_div_q <= tx_bit_end ? '0 : tx_div_q + CNT_W'(1);
      if (tx_pop) begin
        tx_state_q <= S_START;
        tx_shift_q <= tx_head;
        tx_par_q   <= tx_head_par;
        tx_bit_q   <= '0;
        txd_q      <= 1'b0;
      end else if (tx_bit_end) begin
        case (tx_state_q)
          S_START: begin
            tx_state_q <= S_DATA;
            txd_q      <= tx_shift_q[0];
          end
          S_DATA: begin
            if (tx_bit_q == BIT_W'(DATA_BITS - 1)) begin
              tx_bit_q <= '0;
              if (PARITY != 0) begin
                tx_state_q <= S_PAR;
                txd_q      <= tx_par_q;
              end else begin
                tx_state_q <= S_STOP;
                txd_q      <= 1'b1;
              end
            end else begin
              tx_bit_q   <= tx_bit_q + BIT_W'(1);
              tx_shift_q <= tx_shift_q >> 1;
              txd_q      <= tx_shift_q[1];
            end
          end
          S_PAR: begin
            tx_state_q <= S_STOP;
            txd_q      <= 1'b1;
          end
          S_STOP: begin
            if (tx_bit_q == BIT_W'(STOP_BITS - 1)) tx_state_q <= S_IDLE;
            else                                   tx_bit_q   <= tx_bit_q + BIT_W'(1);
          end
          default: tx_state_q <= S_IDLE;
        endcase
      end
    end
  end

  // ---------------- RX FSM ----------------
  state_e               rx_state_q;
  logic [CNT_W-1:0]     rx_div_q;
  logic [BIT_W-1:0]     rx_bit_q;
  logic [DATA_BITS-1:0] rx_shift_q;
  logic                 rx_par_q, rx_done_q, err_frame_q, err_parity_q;
  logic                 rx_bit_end, rx_par_bad;

  assign rx_bit_end = (rx_div_q == CNT_W'(CLK_DIV - 1));
  assign rx_par_bad = (PARITY == 1) ? ~^{rx_shift_q, rx_par_q} : ^{rx_shift_q, rx_par_q};

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      rx_state_q   <= S_IDLE;
      rx_div_q     <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      rx_par_q     <= 1'b0;
      rx_done_q    <= 1'b0;
      err_frame_q  <= 1'b0;
      err_parity_q <= 1'b0;
    end else begin
      rx_done_q    <= 1'b0;
      err_frame_q  <= 1'b0;
      err_parity_q <= 1'b0;
      case (rx_state_q)
        S_IDLE: begin
          rx_div_q <= '0;
          if (rx_prev_q && !rx_s) rx_state_q <= S_START;
        end
        S_START: begin
          // Mid-bit check of the start bit; a high line means it was a glitch
          if (rx_div_q == CNT_W'(HALF - 1)) begin
            rx_div_q   <= '0;
            rx_bit_q   <= '0;
            rx_state_q <= rx_s ? S_IDLE : S_DATA;
          end else begin
            rx_div_q <= rx_div_q + CNT_W'(1);
          end
        end
        S_DATA: begin
          rx_div_q <= rx_bit_end ? '0 : rx_div_q + CNT_W'(1);
          if (rx_bit_end) begin
            rx_shift_q <= {rx_s, rx_shift_q[DATA_BITS-1:1]};
            if (rx_bit_q == BIT_W'(DATA_BITS - 1)) begin
              rx_state_q <= (PARITY != 0) ? S_PAR : S_STOP;
            end else begin
              rx_bit_q <= rx_bit_q + BIT_W'(1);
            end
          end
        end
        S_PAR: begin
          rx_div_q <= rx_bit_end ? '0 : rx_div_q + CNT_W'(1);
          if (rx_bit_end) begin
            rx_par_q   <= rx_s;
            rx_state_q <= S_STOP;
          end
        end
        S_STOP: begin
          rx_div_q <= rx_bit_end ? '0 : rx_div_q + CNT_W'(1);
          if (rx_bit_end) begin
            rx_state_q <= S_IDLE;
            if (!rx_s)                            err_frame_q  <= 1'b1;
            else if ((PARITY != 0) && rx_par_bad) err_parity_q <= 1'b1;
            else                                  rx_done_q    <= 1'b1;
          end
        end
        default: rx_state_q <= S_IDLE;
      endcase
    end
  end

  // ---------------- RX FIFO ----------------
  logic [DATA_BITS-1:0] rx_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     rx_wp_q, rx_rp_q, rx_rp_d;
  logic [LVL_W-1:0]     rx_cnt_q, rx_cnt_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rts_n_q, err_overrun_q;
  logic                 rx_pop, rx_full, rx_push;

  assign rx_pop  = rx_ready && rx_valid_q;
  assign rx_full = (rx_cnt_q == LVL_W'(FIFO_DEPTH));
  // A pop in the same cycle frees the slot before the push is judged
  assign rx_push = rx_done_q && (!rx_full || rx_pop);
  assign rx_rp_d = rx_pop ? rx_rp_q + PTR_W'(1) : rx_rp_q;

  always_comb begin
    rx_cnt_d = rx_cnt_q;
    if (rx_push && !rx_pop)      rx_cnt_d = rx_cnt_q + LVL_W'(1);
    else if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - LVL_W'(1);
    // Registered head: bypass the incoming byte when it lands at the new read slot
    rx_data_d = (rx_push && (rx_wp_q == rx_rp_d)) ? rx_shift_q : rx_mem_q[rx_rp_d];
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      rx_wp_q       <= '0;
      rx_rp_q       <= '0;
      rx_cnt_q      <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      rts_n_q       <= 1'b1;
      err_overrun_q <= 1'b0;
    end else begin
      if (rx_push) rx_wp_q <= rx_wp_q + PTR_W'(1);
      rx_rp_q       <= rx_rp_d;
      rx_cnt_q      <= rx_cnt_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= (rx_cnt_d != '0);
      rts_n_q       <= (rx_cnt_d >= LVL_W'(RTS_THR));
      err_overrun_q <= rx_done_q && rx_full && !rx_pop;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (rx_push) rx_mem_q[rx_wp_q] <= rx_shift_q;
  end

  assign tx_ready    = tx_ready_q;
  assign tx_level    = tx_cnt_q;
  assign txd         = txd_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign rx_level    = rx_cnt_q;
  assign rts_n       = rts_n_q;
  assign err_frame   = err_frame_q;
  assign err_parity  = err_parity_q;
  assign err_overrun = err_overrun_q;

endmodule

// File: tb/tb_wifi_uart_fc.sv
// tb_wifi_uart_fc: directed bench with an 8N1 instance (a) and an even-parity instance (b).
// Both instances use 8 clocks per bit and share the clock and reset.
module tb_wifi_uart_fc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] tx_data_a, rx_data_a, tx_data_b, rx_data_b;
  logic       tx_valid_a, tx_ready_a, rx_valid_a, rx_ready_a;
  logic       tx_valid_b, tx_ready_b, rx_valid_b, rx_ready_b;
  logic [4:0] tx_level_a, rx_level_a, tx_level_b, rx_level_b;
  logic       ef_a_o, ep_a_o, eo_a_o, ef_b_o, ep_b_o, eo_b_o;
  logic       rxd_a, txd_a, cts_n_a, rts_n_a, loop_a, line_a;
  logic       txd_b, cts_n_b, rts_n_b, line_b;

  assign rxd_a = loop_a ? txd_a : line_a;

  wifi_uart_fc #(.CLK_DIV(8), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
                 .FIFO_DEPTH(16), .RTS_MARGIN(4)) u_dut_a (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
    .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_ready(rx_ready_a),
    .tx_level(tx_level_a), .rx_level(rx_level_a),
    .err_frame(ef_a_o), .err_parity(ep_a_o), .err_overrun(eo_a_o),
    .rxd(rxd_a), .txd(txd_a), .cts_n(cts_n_a), .rts_n(rts_n_a));

  wifi_uart_fc #(.CLK_DIV(8), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1),
                 .FIFO_DEPTH(16), .RTS_MARGIN(4)) u_dut_b (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
    .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_ready(rx_ready_b),
    .tx_level(tx_level_b), .rx_level(rx_level_b),
    .err_frame(ef_b_o), .err_parity(ep_b_o), .err_overrun(eo_b_o),
    .rxd(line_b), .txd(txd_b), .cts_n(cts_n_b), .rts_n(rts_n_b));

  int n_checks = 0;
  int n_fail   = 0;
  int ef_a = 0, ep_a = 0, eo_a = 0, ef_b = 0, ep_b = 0, eo_b = 0;

  // Error pulse counters
  always @(negedge clk) begin
    if (ef_a_o) ef_a++;
    if (ep_a_o) ep_a++;
    if (eo_a_o) eo_a++;
    if (ef_b_o) ef_b++;
    if (ep_b_o) ep_b++;
    if (eo_b_o) eo_b++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic txd_of(input int tgt);
    return (tgt == 1) ? txd_b : txd_a;
  endfunction

  task automatic push(input int tgt, input logic [7:0] d);
    if (tgt == 1) begin tx_data_b = d; tx_valid_b = 1'b1; end
    else          begin tx_data_a = d; tx_valid_a = 1'b1; end
    tick();
    tx_valid_a = 1'b0;
    tx_valid_b = 1'b0;
  endtask

  task automatic pop(input int tgt, input string tag, input logic [7:0] exp);
    int w = 0;
    while (((tgt == 1) ? rx_valid_b : rx_valid_a) !== 1'b1 && w < 400) begin
      tick();
      w++;
    end
    chk({tag, "_valid"}, (tgt == 1) ? rx_valid_b : rx_valid_a, 1);
    chk({tag, "_data"}, (tgt == 1) ? rx_data_b : rx_data_a, exp);
    if (tgt == 1) rx_ready_b = 1'b1; else rx_ready_a = 1'b1;
    tick();
    rx_ready_a = 1'b0;
    rx_ready_b = 1'b0;
  endtask

  task automatic wait_start(input int tgt, input string tag);
    int w = 0;
    while (txd_of(tgt) !== 1'b0 && w < 2000) begin
      tick();
      w++;
    end
    chk({tag, "_start_seen"}, txd_of(tgt), 0);
  endtask

  // Called on the first cycle txd is low; samples the middle of each bit
  task automatic check_frame(input int tgt, input string tag, input logic [31:0] bits, input int n);
    tick(4);
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s_bit%0d", tag, k), txd_of(tgt), bits[k]);
      tick(8);
    end
  endtask

  task automatic serial(input int tgt, input logic [31:0] bits, input int n);
    for (int k = 0; k < n; k++) begin
      if (tgt == 1) line_b = bits[k]; else line_a = bits[k];
      tick(8);
    end
    if (tgt == 1) line_b = 1'b1; else line_a = 1'b1;
  endtask

  task automatic count_low(input int tgt, input int cycles, output int low);
    low = 0;
    repeat (cycles) begin
      tick();
      if (txd_of(tgt) !== 1'b1) low++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int low;
    logic [7:0] d;
    rst_n = 1'b0;
    tx_data_a = '0; tx_valid_a = 1'b0; rx_ready_a = 1'b0; cts_n_a = 1'b1;
    tx_data_b = '0; tx_valid_b = 1'b0; rx_ready_b = 1'b0; cts_n_b = 1'b1;
    loop_a = 1'b1; line_a = 1'b1; line_b = 1'b1;
    tick(3);

    chk("rst_txd", txd_a, 1);
    chk("rst_rts_n", rts_n_a, 1);
    chk("rst_tx_ready", tx_ready_a, 0);
    chk("rst_rx_valid", rx_valid_a, 0);
    chk("rst_tx_level", tx_level_a, 0);
    chk("rst_rx_level", rx_level_a, 0);
    chk("rst_errs", {ef_a_o, ep_a_o, eo_a_o}, 0);
    chk("rst_txd_b", txd_b, 1);

    rst_n = 1'b1;
    tick();
    chk("rel_tx_ready", tx_ready_a, 1);
    chk("rel_rts_n", rts_n_a, 0);

    // 0xA5 waveform, looped back into the receiver
    cts_n_a = 1'b0;
    tick(4);
    push(0, 8'hA5);
    chk("a5_level_pushed", tx_level_a, 1);
    chk("a5_txd_idle", txd_a, 1);
    tick();
    chk("a5_level_popped", tx_level_a, 0);
    chk("a5_txd_start", txd_a, 0);
    check_frame(0, "a5", {1'b1, 8'hA5, 1'b0}, 10);
    pop(0, "rx_a5", 8'hA5);

    push(0, 8'h00);
    push(0, 8'hFF);
    push(0, 8'h3C);
    pop(0, "lb_00", 8'h00);
    pop(0, "lb_ff", 8'hFF);
    pop(0, "lb_3c", 8'h3C);
    chk("lb_err_frame", ef_a, 0);
    chk("lb_err_parity", ep_a, 0);
    chk("lb_err_overrun", eo_a, 0);

    // CTS held off, then released: three frames back to back
    cts_n_a = 1'b1;
    tick(4);
    push(0, 8'h11);
    push(0, 8'h22);
    push(0, 8'h33);
    count_low(0, 60, low);
    chk("cts_hold_txd_low", low, 0);
    chk("cts_hold_level", tx_level_a, 3);
    cts_n_a = 1'b0;
    wait_start(0, "b2b");
    check_frame(0, "b2b", {1'b1, 8'h33, 1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 1'b0}, 30);
    chk("b2b_level", tx_level_a, 0);

    // CTS raised during frame 1: it completes, frame 2 waits
    cts_n_a = 1'b1;
    tick(4);
    push(0, 8'h44);
    push(0, 8'h55);
    cts_n_a = 1'b0;
    wait_start(0, "mid");
    cts_n_a = 1'b1;
    check_frame(0, "mid44", {1'b1, 8'h44, 1'b0}, 10);
    count_low(0, 60, low);
    chk("mid_hold_txd_low", low, 0);
    chk("mid_hold_level", tx_level_a, 1);
    cts_n_a = 1'b0;
    wait_start(0, "mid55");
    check_frame(0, "mid55", {1'b1, 8'h55, 1'b0}, 10);

    chk("lb5_rx_level", rx_level_a, 5);
    chk("lb5_rts_n", rts_n_a, 0);
    pop(0, "lb_11", 8'h11);
    pop(0, "lb_22", 8'h22);
    pop(0, "lb_33", 8'h33);
    pop(0, "lb_44", 8'h44);
    pop(0, "lb_55", 8'h55);

    // Fill the RX FIFO with the consumer stalled
    loop_a = 1'b0;
    tick(10);
    for (int k = 0; k < 16; k++) begin
      d = 8'(k * 13 + 1);
      serial(0, {1'b1, d, 1'b0}, 10);
      tick(8);
      chk($sformatf("fill%0d_level", k), rx_level_a, k + 1);
      chk($sformatf("fill%0d_rts_n", k), rts_n_a, (k + 1 >= 12) ? 1 : 0);
    end
    serial(0, {1'b1, 8'hEE, 1'b0}, 10);
    tick(8);
    chk("ovr_pulse", eo_a, 1);
    chk("ovr_level", rx_level_a, 16);
    chk("ovr_rts_n", rts_n_a, 1);

    // Pop in the same cycle as a push into the full FIFO
    fork
      serial(0, {1'b1, 8'h5A, 1'b0}, 10);
      begin
        tick(79);
        rx_ready_a = 1'b1;
        tick();
        rx_ready_a = 1'b0;
      end
    join
    tick(8);
    chk("simul_no_ovr", eo_a, 1);
    chk("simul_level", rx_level_a, 16);

    for (int i = 0; i < 16; i++) begin
      d = (i < 15) ? 8'((i + 1) * 13 + 1) : 8'h5A;
      pop(0, $sformatf("drain%0d", i), d);
      chk($sformatf("drain%0d_level", i), rx_level_a, 15 - i);
      chk($sformatf("drain%0d_rts_n", i), rts_n_a, (15 - i >= 12) ? 1 : 0);
    end
    chk("fill_err_frame", ef_a, 0);
    chk("fill_err_parity", ep_a, 0);

    // Even-parity receiver: 0x07 has three ones, so the correct parity bit is 1
    serial(1, {1'b1, 1'b0, 8'h07, 1'b0}, 11);
    tick(8);
    chk("par_bad_pulse", ep_b, 1);
    chk("par_bad_no_frame", ef_b, 0);
    chk("par_bad_level", rx_level_b, 0);
    serial(1, {1'b1, 1'b1, 8'h07, 1'b0}, 11);
    tick(8);
    chk("par_good_level", rx_level_b, 1);
    chk("par_good_data", rx_data_b, 8'h07);
    chk("par_good_no_err", ep_b, 1);
    serial(1, {1'b0, 1'b1, 8'h07, 1'b0}, 11);
    tick(8);
    chk("stop0_frame", ef_b, 1);
    chk("stop0_parity", ep_b, 1);
    chk("stop0_level", rx_level_b, 1);
    serial(1, {1'b0, 1'b0, 8'h07, 1'b0}, 11);
    tick(8);
    chk("both_bad_frame", ef_b, 2);
    chk("both_bad_parity", ep_b, 1);
    line_b = 1'b0;
    tick(2);
    line_b = 1'b1;
    tick(40);
    chk("glitch_level", rx_level_b, 1);
    chk("glitch_frame", ef_b, 2);
    chk("glitch_parity", ep_b, 1);
    chk("b_overrun", eo_b, 0);
    pop(1, "par_pop", 8'h07);

    // Even-parity transmitter
    cts_n_b = 1'b0;
    tick(4);
    push(1, 8'h07);
    wait_start(1, "btx");
    check_frame(1, "btx07", {1'b1, 1'b1, 8'h07, 1'b0}, 11);

    // Reset in the middle of a TX frame
    loop_a = 1'b1;
    push(0, 8'hC3);
    push(0, 8'h99);
    wait_start(0, "rst");
    tick(28);
    chk("rst_mid_txd_before", txd_a, 0);
    chk("rst_mid_level_before", tx_level_a, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_txd", txd_a, 1);
    chk("rst_mid_tx_level", tx_level_a, 0);
    chk("rst_mid_rx_level", rx_level_a, 0);
    chk("rst_mid_rts_n", rts_n_a, 1);
    chk("rst_mid_rx_valid", rx_valid_a, 0);
    tick(2);
    rst_n = 1'b1;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
